note_judge: RTL and testbench

- Single-lane hit judge for the rhythm game, sitting directly upstream of the piezo sound stage.
- Keeps a millisecond song clock and queues note target times from the note sequencer.
- Debounces the player button and grades each press as Perfect, Good or Miss.
- Emits a one-cycle sound command (0 None, 1 Perfect, 2 Good, 3 Miss) plus score and combo.

---
 rtl/note_judge.sv | 171 +++++++++++++++++
 tb/tb_note_judge.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_judge.sv
// note_judge: single-lane rhythm-game hit judge.
// Song clock, note queue, debounced button and Perfect/Good/Miss grading.
module note_judge #(
  parameter int CLK_DIV     = 50000,
  parameter int DEBOUNCE_MS = 5,
  parameter int PERF_WIN    = 30,
  parameter int GOOD_WIN    = 80,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Btn,
  input  logic        i_Note_Push,
  input  logic [15:0] i_Note_Time,
  output logic [15:0] o_Time,
  output logic [1:0]  o_Sound_Cmd,
  output logic [15:0] o_Score,
  output logic [7:0]  o_Combo,
  output logic        o_Empty,
  output logic        o_Full,
  output logic        o_Overflow
);
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic signed [15:0] GW_S = 16'(GOOD_WIN);
  localparam logic [15:0] GW_U = 16'(GOOD_WIN);
  localparam logic [15:0] PW_U = 16'(PERF_WIN);

  typedef enum logic [1:0] {
    RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT
  } db_state_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          sync1, sync2, press;
  db_state_t     db_state;
  logic [DW-1:0] db_cnt;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   head, adiff;
  logic signed [15:0] diff;
  logic          miss, hit, perf, hit_perf, hit_good;
  logic          pop, push_ok;
  logic [16:0]   score_sum;

  assign tick = (tick_cnt == TW'(CLK_DIV - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tick_cnt <= '0;
      o_Time   <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      o_Time   <= o_Time + 16'd1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // press is a one-cycle pulse on entry to PRESSED from PRESS_WAIT only
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_state <= RELEASED;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= i_Btn;
      sync2 <= sync1;
      press <= 1'b0;
      case (db_state)
        RELEASED:
          if (sync2) begin
            db_state <= PRESS_WAIT;
            db_cnt   <= '0;
          end
        PRESS_WAIT:
          if (!sync2) begin
            db_state <= RELEASED;
          end else if (tick) begin
            if (db_cnt == DW'(DEBOUNCE_MS - 1)) begin
              db_state <= PRESSED;
              press    <= 1'b1;
            end else begin
              db_cnt <= db_cnt + DW'(1);
            end
          end
        PRESSED:
          if (!sync2) begin
            db_state <= RELEASE_WAIT;
            db_cnt   <= '0;
          end
        RELEASE_WAIT:
          if (sync2) begin
            db_state <= PRESSED;
          end else if (tick) begin
            if (db_cnt == DW'(DEBOUNCE_MS - 1))
              db_state <= RELEASED;
            else
              db_cnt <= db_cnt + DW'(1);
          end
        default: db_state <= RELEASED;
      endcase
    end
  end

  assign o_Empty = (count == '0);
  assign o_Full  = (count == CW'(FIFO_DEPTH));
  assign head    = mem[rd_ptr];

  // signed distance from target; positive means late
  assign diff     = $signed(o_Time - head);
  assign adiff    = diff[15] ? 16'(-diff) : 16'(diff);
  assign miss     = !o_Empty && (diff > GW_S);
  assign hit      = press && !o_Empty && (adiff <= GW_U);
  assign perf     = (adiff <= PW_U);
  assign hit_perf = hit && perf;
  assign hit_good = hit && !perf;
  assign pop      = miss || hit;
  assign push_ok  = i_Note_Push && (!o_Full || pop);

  always_ff @(posedge i_Clk) begin
    if (push_ok) mem[wr_ptr] <= i_Note_Time;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (i_Note_Push && !push_ok) o_Overflow <= 1'b1;
    end
  end

  assign score_sum = {1'b0, o_Score} + (perf ? 17'd2 : 17'd1);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Sound_Cmd <= 2'd0;
      o_Score     <= '0;
      o_Combo     <= '0;
    end else begin
      o_Sound_Cmd <= 2'd0;
      unique case (1'b1)
        miss: begin
          o_Sound_Cmd <= 2'd3;
          o_Combo     <= '0;
        end
        hit_perf, hit_good: begin
          o_Sound_Cmd <= hit_perf ? 2'd1 : 2'd2;
          o_Score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          o_Combo     <= (o_Combo == 8'hFF) ? o_Combo : o_Combo + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: directed table, corner sequences and random
// scoreboard for note_judge, plus a fast-tick instance for wrap.
module tb_note_judge;
  localparam int CDIV = 4;
  localparam int DBMS = 2;
  localparam int OP_PUSH = 0;
  localparam int OP_PRESS = 1;
  localparam int OP_MISS = 2;

  typedef struct {
    int op;
    int t;
    int cmd;
    int score;
    int combo;
    int empty;
  } step_t;

  logic clk = 1'b0;
  logic rst_n, btn, push;
  logic [15:0] ntime, time_o, score;
  logic [1:0] cmd;
  logic [7:0] combo;
  logic empty, full, ovf;

  logic rst2_n, btn2, push2;
  logic [15:0] ntime2, time2, score2;
  logic [1:0] cmd2;
  logic [7:0] combo2;
  logic empty2, full2, ovf2;

  note_judge #(.CLK_DIV(CDIV), .DEBOUNCE_MS(DBMS)) u_dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Btn(btn),
    .i_Note_Push(push), .i_Note_Time(ntime),
    .o_Time(time_o), .o_Sound_Cmd(cmd), .o_Score(score),
    .o_Combo(combo), .o_Empty(empty), .o_Full(full),
    .o_Overflow(ovf)
  );

  note_judge #(.CLK_DIV(1), .DEBOUNCE_MS(DBMS)) u_wrap (
    .i_Clk(clk), .i_Rst_n(rst2_n), .i_Btn(btn2),
    .i_Note_Push(push2), .i_Note_Time(ntime2),
    .o_Time(time2), .o_Sound_Cmd(cmd2), .o_Score(score2),
    .o_Combo(combo2), .o_Empty(empty2), .o_Full(full2),
    .o_Overflow(ovf2)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  int ecnt2 = 0;
  always @(posedge clk) ecnt <= rst_n ? ecnt + 1 : 0;
  always @(posedge clk) ecnt2 <= rst2_n ? ecnt2 + 1 : 0;

  int checks = 0;
  int failures = 0;
  int score_m, combo_m, n, d, tgt, kind, exp_cmd;
  logic [1:0] c;
  step_t steps[6];

  function automatic int mtime();
    return ecnt / CDIV;
  endfunction

  function automatic int grade(input int df);
    if (df > 80) return 3;
    if (df < -80) return 0;
    if (df >= -30 && df <= 30) return 1;
    return 2;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_until(input int ms);
    while (ecnt < ms * CDIV) @(negedge clk);
  endtask

  task automatic push_note(input int t);
    push = 1'b1;
    ntime = 16'(t);
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_cmd(input bit w, input int budget,
                          output logic [1:0] cr);
    cr = 2'd0;
    for (int i = 0; i < budget && cr == 2'd0; i++) begin
      @(negedge clk);
      cr = w ? cmd2 : cmd;
    end
  endtask

  task automatic count_cmds_until(input int ms, output int cnt);
    cnt = 0;
    while (ecnt < ms * CDIV) begin
      @(negedge clk);
      if (cmd != 2'd0) cnt++;
    end
  endtask

  task automatic chk_state(input string nm, input int ec,
                           input int es, input int eb, input int ee);
    chk({nm, "_cmd"}, int'(c), ec);
    chk({nm, "_score"}, int'(score), es);
    chk({nm, "_combo"}, int'(combo), eb);
    chk({nm, "_empty"}, int'(empty), ee);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; btn = 1'b0; push = 1'b0; ntime = '0;
    rst2_n = 1'b0; btn2 = 1'b0; push2 = 1'b0; ntime2 = '0;
    steps = '{
      '{OP_PUSH,  100, 0, 0, 0, 0},
      '{OP_PUSH,  200, 0, 0, 0, 0},
      '{OP_PRESS, 110, 1, 2, 1, 0},
      '{OP_PRESS, 255, 2, 3, 2, 1},
      '{OP_PUSH,  300, 0, 0, 0, 0},
      '{OP_MISS,  381, 3, 3, 0, 1}
    };
    repeat (3) @(negedge clk);
    chk("rst_time", int'(time_o), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    rst2_n = 1'b1;

    wait_until(3);
    chk("time_run", int'(time_o), mtime());

    for (int i = 0; i < 6; i++) begin
      case (steps[i].op)
        OP_PUSH: push_note(steps[i].t);
        OP_PRESS: begin
          wait_until(steps[i].t - 2);
          btn = 1'b1;
          wait_cmd(1'b0, 15 * CDIV, c);
          chk_state($sformatf("step%0d", i), steps[i].cmd,
                    steps[i].score, steps[i].combo, steps[i].empty);
          @(negedge clk);
          chk("pulse_width", int'(cmd), 0);
          btn = 1'b0;
          repeat (8 * CDIV) @(negedge clk);
        end
        default: begin
          wait_cmd(1'b0, 400 * CDIV, c);
          chk("miss_time", mtime(), steps[i].t);
          chk_state($sformatf("step%0d", i), steps[i].cmd,
                    steps[i].score, steps[i].combo, steps[i].empty);
          @(negedge clk);
          chk("miss_width", int'(cmd), 0);
        end
      endcase
    end

    // bounce then early hold, then a real press and two expiries
    push_note(500);
    push_note(510);
    push_note(510);
    wait_until(400);
    repeat (3) begin
      btn = 1'b1;
      repeat (CDIV) @(negedge clk);
      btn = 1'b0;
      repeat (CDIV) @(negedge clk);
    end
    wait_until(408);
    btn = 1'b1;
    count_cmds_until(440, n);
    chk("early_ignored", n, 0);
    chk("early_score", int'(score), 3);
    chk("early_empty", int'(empty), 0);
    btn = 1'b0;
    wait_until(498);
    btn = 1'b1;
    wait_cmd(1'b0, 15 * CDIV, c);
    chk_state("press500", 1, 5, 1, 0);
    count_cmds_until(560, n);
    chk("hold_no_repeat", n, 0);
    btn = 1'b0;
    wait_cmd(1'b0, 100 * CDIV, c);
    chk("miss510_time", mtime(), 591);
    chk_state("miss510", 3, 5, 0, 0);
    @(negedge clk);
    chk("b2b_miss", int'(cmd), 3);
    chk("b2b_empty", int'(empty), 1);
    @(negedge clk);
    chk("b2b_end", int'(cmd), 0);

    // overflow and push-while-full alongside a miss pop
    wait_until(600);
    repeat (4) push_note(700);
    chk("full4", int'(full), 1);
    chk("ovf_before", int'(ovf), 0);
    push_note(800);
    chk("ovf_set", int'(ovf), 1);
    chk("full_kept", int'(full), 1);
    wait_until(781);
    push = 1'b1;
    ntime = 16'd900;
    @(negedge clk);
    push = 1'b0;
    chk("full_pop_cmd", int'(cmd), 3);
    chk("full_pop_full", int'(full), 1);
    chk("full_pop_ovf", int'(ovf), 1);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (cmd == 2'd3) n++;
    end
    chk("miss_train", n, 3);
    chk("train_empty", int'(empty), 0);
    @(negedge clk);
    chk("train_end", int'(cmd), 0);
    wait_cmd(1'b0, 300 * CDIV, c);
    chk("miss900_time", mtime(), 981);
    chk_state("miss900", 3, 5, 0, 1);
    chk("ovf_sticky", int'(ovf), 1);

    // random single-note scenarios against a grading model
    score_m = 5;
    combo_m = 0;
    for (int it = 0; it < 15; it++) begin
      tgt = mtime() + 105 + int'($urandom_range(0, 50));
      push_note(tgt);
      kind = int'($urandom_range(0, 4));
      case (kind)
        1: d = int'($urandom_range(0, 48)) - 24;
        2: d = int'($urandom_range(36, 74));
        3: d = -int'($urandom_range(36, 74));
        4: d = -100;
        default: d = 200;
      endcase
      exp_cmd = grade(d);
      if (kind != 0) begin
        wait_until(tgt + d - 2);
        btn = 1'b1;
        if (exp_cmd == 0) begin
          count_cmds_until(tgt + d + 8, n);
          chk("rnd_early", n, 0);
        end else begin
          wait_cmd(1'b0, 15 * CDIV, c);
          score_m += (exp_cmd == 1) ? 2 : 1;
          if (score_m > 65535) score_m = 65535;
          if (combo_m < 255) combo_m++;
          chk_state($sformatf("rnd%0d", it), exp_cmd,
                    score_m, combo_m, 1);
        end
        btn = 1'b0;
        repeat (8 * CDIV) @(negedge clk);
      end
      if (kind == 0 || exp_cmd == 0) begin
        wait_cmd(1'b0, 300 * CDIV, c);
        combo_m = 0;
        chk("rnd_miss_time", mtime(), tgt + 81);
        chk_state($sformatf("rndm%0d", it), 3,
                  score_m, combo_m, 1);
      end
    end

    // song clock wrap on the fast-tick instance
    while (ecnt2 < 65530) @(negedge clk);
    chk("wrap_pre", int'(time2), 65530);
    push2 = 1'b1;
    ntime2 = 16'd4;
    @(negedge clk);
    push2 = 1'b0;
    while (ecnt2 < 65533) @(negedge clk);
    btn2 = 1'b1;
    wait_cmd(1'b1, 30, c);
    chk("wrap_cmd", int'(c), 1);
    chk("wrap_score", int'(score2), 2);
    chk("wrap_combo", int'(combo2), 1);
    chk("wrap_empty", int'(empty2), 1);
    chk("wrap_time", int'(time2), ecnt2 % 65536);
    btn2 = 1'b0;
    repeat (10) @(negedge clk);
    btn2 = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst2_n = 1'b0;
    #1;
    chk("arst_time", int'(time2), 0);
    chk("arst_cmd", int'(cmd2), 0);
    chk("arst_score", int'(score2), 0);
    chk("arst_combo", int'(combo2), 0);
    chk("arst_empty", int'(empty2), 1);
    chk("arst_full", int'(full2), 0);
    chk("arst_ovf", int'(ovf2), 0);
    btn2 = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
